comparison_flag_unit: RTL and testbench

- Multi-cycle subtractor that computes opA - opB one CHUNK-bit slice per cycle, LSB slice first.
- Produces the sign, carry, zero, diff and overflow flags consumed by the downstream comparison stage, along with the full difference word.
- Sits directly upstream of the comparison stage. It forwards the latched 3-bit comparison opcode alongside the flags so the two stay aligned.
- Start/busy/done handshake. Outputs are held stable between completions.

---
 rtl/comparison_flag_unit.sv | 148 ++++++++++++++
 tb/tb_comparison_flag_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparison_flag_unit.sv
// Purpose : multi-cycle subtractor producing opA - opB and the sign/carry/zero/overflow flags for the comparison stage.
// Latency : N = WIDTH/CHUNK cycles from accepted start to the done pulse; results held until the next completion.
// Backpres: start is ignored while busy; a start in the done cycle is accepted back-to-back.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset (clears state and all outputs)
//   start, opA, opB, opcodeIn - request plus operands/opcode, sampled only when not busy
//   busy, done                - busy while slices are processed; done pulses one cycle on completion
//   opcodeOut, aSign, bSign   - opcode and operand sign bits of the completed operation
//   carryFlag, zeroFlag       - no-borrow flag (opA >= opB unsigned) and all-zero difference
//   diff, overflowFlag        - difference MSB and signed overflow of the subtraction
//   difference                - opA - opB modulo 2^WIDTH
module comparison_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       opcodeIn,
  output logic             busy,
  output logic             done,
  output logic [2:0]       opcodeOut,
  output logic             aSign,
  output logic             bSign,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             diff,
  output logic             overflowFlag,
  output logic [WIDTH-1:0] difference
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  // Working registers for the operation in flight.
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] diffW;
  logic [2:0]       opReg;
  logic             carryW;
  logic             zeroW;
  logic [CW-1:0]    cnt;

  // Slice datapath.
  logic [CHUNK-1:0] aSlice;
  logic [CHUNK-1:0] bSlice;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] diffNext;
  logic             lastSlice;
  logic             sliceZero;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    aSlice    = aReg[int'(cnt)*CHUNK +: CHUNK];
    bSlice    = bReg[int'(cnt)*CHUNK +: CHUNK];
    // Subtraction as opA + ~opB + carry; carry starts at 1 to form the two's complement.
    sum       = {1'b0, aSlice} + {1'b0, ~bSlice} + {{CHUNK{1'b0}}, carryW};
    sliceZero = (sum[CHUNK-1:0] == '0);
    // Full word including the slice being written this cycle, so the completion
    // edge can load the output registers without waiting for diffW to settle.
    diffNext  = diffW;
    diffNext[int'(cnt)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    lastSlice = (cnt == CW'(N - 1));
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastSlice) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aReg         <= '0;
      bReg         <= '0;
      diffW        <= '0;
      opReg        <= '0;
      carryW       <= 1'b0;
      zeroW        <= 1'b0;
      cnt          <= '0;
      opcodeOut    <= '0;
      aSign        <= 1'b0;
      bSign        <= 1'b0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      diff         <= 1'b0;
      overflowFlag <= 1'b0;
      difference   <= '0;
    end else if (state != RUN) begin
      if (start) begin
        aReg   <= opA;
        bReg   <= opB;
        opReg  <= opcodeIn;
        diffW  <= '0;
        carryW <= 1'b1;
        zeroW  <= 1'b1;
        cnt    <= '0;
      end
    end else begin
      diffW  <= diffNext;
      carryW <= sum[CHUNK];
      zeroW  <= zeroW & sliceZero;
      if (lastSlice) begin
        // Counter returns to 0 here so it never runs past the last slice.
        cnt          <= '0;
        difference   <= diffNext;
        carryFlag    <= sum[CHUNK];
        zeroFlag     <= zeroW & sliceZero;
        diff         <= diffNext[WIDTH-1];
        aSign        <= aReg[WIDTH-1];
        bSign        <= bReg[WIDTH-1];
        opcodeOut    <= opReg;
        // Overflow only when operand signs differ and the result sign departs from opA.
        overflowFlag <= (aReg[WIDTH-1] != bReg[WIDTH-1]) &&
                        (diffNext[WIDTH-1] != aReg[WIDTH-1]);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_comparison_flag_unit.sv
module tb_comparison_flag_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  typedef struct packed {
    logic [2:0]  op;
    logic        aS;
    logic        bS;
    logic        c;
    logic        z;
    logic        d;
    logic        v;
    logic [31:0] dif;
  } res_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [2:0]  opcodeIn;
  logic        busy;
  logic        done;
  logic [2:0]  opcodeOut;
  logic        aSign;
  logic        bSign;
  logic        carryFlag;
  logic        zeroFlag;
  logic        diff;
  logic        overflowFlag;
  logic [31:0] difference;

  int nChecks = 0;
  int nFail   = 0;

  res_t got;
  assign got = '{opcodeOut, aSign, bSign, carryFlag, zeroFlag, diff, overflowFlag, difference};

  comparison_flag_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB), .opcodeIn(opcodeIn),
    .busy(busy), .done(done), .opcodeOut(opcodeOut), .aSign(aSign), .bSign(bSign),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .diff(diff), .overflowFlag(overflowFlag),
    .difference(difference)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags from plain integer arithmetic on the whole words.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    res_t r;
    longint sd;
    r.op  = op;
    r.aS  = a[31];
    r.bS  = b[31];
    r.dif = a - b;
    r.c   = (a >= b);
    r.z   = (a == b);
    r.d   = r.dif[31];
    sd    = longint'($signed(a)) - longint'($signed(b));
    r.v   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  // Drives one request, then records busy/done per cycle (bit k = k cycles after
  // acceptance). Optionally re-pulses start or asserts rst before edge k.
  // stable reports whether outputs held their entry value until done.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int pokeAt, input int rstAt,
                       output logic [7:0] bt, output logic [7:0] dt, output logic stable);
    res_t snap;
    snap     = got;
    bt       = '0;
    dt       = '0;
    stable   = 1'b1;
    opA      = a;
    opB      = b;
    opcodeIn = op;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      bt[k] = busy;
      dt[k] = done;
      if (done) break;
      if (got !== snap) stable = 1'b0;
      start = (k == pokeAt);
      if (k == pokeAt) begin
        opA = 32'd0;
        opB = 32'd7;
      end
      rst = (k == rstAt);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b1;
    opA      = 32'h1234_5678;
    opB      = 32'h0000_0001;
    opcodeIn = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    nChecks++;
    if ({busy, done, got} !== '0) begin
      nFail++;
      $display("FAIL reset_state: busy=%b done=%b outs=%h, required all 0", busy, done, got);
    end
    @(posedge clk); #1;
    nChecks++;
    if ({busy, done} !== 2'b00) begin
      nFail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va[5] = '{32'd5, 32'h1234_5678, 32'd3, 32'h8000_0000, 32'h0000_00FF};
    logic [31:0] vb[5] = '{32'd3, 32'h1234_5678, 32'd5, 32'h0000_0001, 32'h0000_0001};
    logic [2:0]  vo[5] = '{3'b101, 3'b010, 3'b001, 3'b110, 3'b011};
    res_t        ve[5] = '{
      '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002},
      '{3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE},
      '{3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF},
      '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00FE}};
    logic [7:0] bt, dt;
    logic       st;
    for (int i = 0; i < 5; i++) begin
      runOp(va[i], vb[i], vo[i], -1, -1, bt, dt, st);
      nChecks++;
      if (bt !== 8'h0F || dt !== 8'h10 || st !== 1'b1) begin
        nFail++;
        $display("FAIL directed_timing[%0d]: busy=%h done=%h stable=%b, required 0f 10 1", i, bt, dt, st);
      end
      nChecks++;
      if (got !== ve[i]) begin
        nFail++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, got, ve[i]);
      end
      @(posedge clk); #1;
      nChecks++;
      if (done !== 1'b0 || busy !== 1'b0 || got !== ve[i]) begin
        nFail++;
        $display("FAIL directed_hold[%0d]: done=%b busy=%b outs=%h, required 0 0 %h", i, done, busy, got, ve[i]);
      end
    end
  endtask

  task automatic test_start_midrun;
    logic [7:0] bt, dt;
    logic       st;
    runOp(32'd100, 32'd40, 3'b100, 1, -1, bt, dt, st);
    nChecks++;
    if (bt !== 8'h0F || dt !== 8'h10 || got !== model(32'd100, 32'd40, 3'b100)) begin
      nFail++;
      $display("FAIL start_midrun: busy=%h done=%h outs=%h, required 0f 10 %h",
               bt, dt, got, model(32'd100, 32'd40, 3'b100));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] bt, dt;
    logic       st;
    runOp(32'h0000_DEAD, 32'h0000_1234, 3'b111, -1, 2, bt, dt, st);
    nChecks++;
    if (bt !== 8'h07 || dt !== 8'h00) begin
      nFail++;
      $display("FAIL reset_midrun_timing: busy=%h done=%h, required 07 00", bt, dt);
    end
    nChecks++;
    if ({busy, done, got} !== '0) begin
      nFail++;
      $display("FAIL reset_midrun_outs: busy=%b done=%b outs=%h, required all 0", busy, done, got);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bt, dt;
    logic       st;
    runOp(32'h0000_0040, 32'h0000_0100, 3'b010, -1, -1, bt, dt, st);
    nChecks++;
    if (got !== model(32'h40, 32'h100, 3'b010)) begin
      nFail++;
      $display("FAIL b2b_first: got %h, required %h", got, model(32'h40, 32'h100, 3'b010));
    end
    // Still in the done cycle: the next request is accepted immediately.
    runOp(32'd10, 32'd10, 3'b011, -1, -1, bt, dt, st);
    nChecks++;
    if (bt !== 8'h0F || dt !== 8'h10 || st !== 1'b1) begin
      nFail++;
      $display("FAIL b2b_timing: busy=%h done=%h held=%b, required 0f 10 1", bt, dt, st);
    end
    nChecks++;
    if (got !== model(32'd10, 32'd10, 3'b011) || zeroFlag !== 1'b1) begin
      nFail++;
      $display("FAIL b2b_second: got %h, required %h", got, model(32'd10, 32'd10, 3'b011));
    end
  endtask

  task automatic test_random;
    logic [7:0]  bt, dt;
    logic        st;
    logic [31:0] a, b;
    logic [2:0]  op;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = a + 32'($urandom_range(0, 3)) - 32'd1;
        2: a = {1'b1, a[30:0]} ^ {1'b0, b[30:0]} ^ {1'b0, b[30:0]};
        default: ;
      endcase
      runOp(a, b, op, -1, -1, bt, dt, st);
      nChecks++;
      if (bt !== 8'h0F || dt !== 8'h10 || st !== 1'b1) begin
        nFail++;
        $display("FAIL random_timing[%0d]: busy=%h done=%h held=%b, required 0f 10 1", i, bt, dt, st);
      end
      nChecks++;
      if (got !== model(a, b, op)) begin
        nFail++;
        $display("FAIL random_result[%0d]: a=%h b=%h got %h, required %h", i, a, b, got, model(a, b, op));
      end
      // Random gap; zero cycles exercises acceptance straight from the done cycle.
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    opA      = '0;
    opB      = '0;
    opcodeIn = '0;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_start_midrun;
    test_back_to_back;
    test_random;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
